// File: rtl/frame_pkg.sv
// frame_pkg: shared types and constants for the camera write path and display window mapping
// Holds the FSM state type, the HDMI/camera geometry constants, the default pixel width
// and the address-width helper used by every frame_writer file.
package frame_pkg;
  typedef enum logic [1:0] {IDLE, ACTIVE, DONE} fw_state_t;
  localparam int HDMI_H = 1280;
  localparam int HDMI_V = 720;
  localparam int CAM_W = 480;
  localparam int CAM_H = 640;
  localparam int DEF_PIX_W = 16;
  function automatic int addr_w(input int w, input int h);
    return $clog2(w * h);
  endfunction
endpackage

// File: rtl/frame_writer_if.sv
// frame_writer_if: camera pixel stream in, frame-buffer write port and status out
// Ports: frame_start_in/pixel_valid_in/pixel_in (camera side), wr_en_out/wr_addr_out/
// wr_data_out/hcount_out/vcount_out (write port), frame_done_out/short_frame_out/overflow_out.
// slave = frame_writer, master = camera/frame-buffer side.
interface frame_writer_if
  import frame_pkg::*;
#(
  parameter int WIDTH = CAM_W,
  parameter int HEIGHT = CAM_H,
  parameter int PIX_W = DEF_PIX_W
);
  localparam int ADDR_W = addr_w(WIDTH, HEIGHT);
  logic frame_start_in;
  logic pixel_valid_in;
  logic [PIX_W-1:0] pixel_in;
  logic wr_en_out;
  logic [ADDR_W:0] wr_addr_out;
  logic [PIX_W-1:0] wr_data_out;
  logic [10:0] hcount_out;
  logic [9:0] vcount_out;
  logic frame_done_out;
  logic short_frame_out;
  logic overflow_out;
  modport slave (
    input frame_start_in, pixel_valid_in, pixel_in,
    output wr_en_out, wr_addr_out, wr_data_out, hcount_out, vcount_out,
    output frame_done_out, short_frame_out, overflow_out
  );
  modport master (
    output frame_start_in, pixel_valid_in, pixel_in,
    input wr_en_out, wr_addr_out, wr_data_out, hcount_out, vcount_out,
    input frame_done_out, short_frame_out, overflow_out
  );
endinterface

// File: rtl/frame_writer_raster_counter.sv
// raster_counter: column/row/linear-address tracker for a WIDTH x HEIGHT raster
// Ports: clk_in, rst_n_in (sync, active-low), clr_in (restart at pixel 0), inc_in (pixel taken),
// h_out/v_out/addr_out = position of the pixel taken this cycle, last_out = that pixel is the last.
// Outputs already account for clr_in so a clear and a pixel in the same cycle land at (0,0).
module raster_counter
  import frame_pkg::*;
#(
  parameter int WIDTH = CAM_W,
  parameter int HEIGHT = CAM_H
) (
  input  logic clk_in,
  input  logic rst_n_in,
  input  logic clr_in,
  input  logic inc_in,
  output logic [10:0] h_out,
  output logic [9:0] v_out,
  output logic [addr_w(WIDTH, HEIGHT)-1:0] addr_out,
  output logic last_out
);
  localparam int ADDR_W = addr_w(WIDTH, HEIGHT);
  localparam logic [10:0] H_LAST = 11'(WIDTH - 1);
  localparam logic [9:0] V_LAST = 10'(HEIGHT - 1);
  logic [10:0] h_q, h_d;
  logic [9:0] v_q, v_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic wrap;
  always_comb begin
    h_out = clr_in ? '0 : h_q;
    v_out = clr_in ? '0 : v_q;
    addr_out = clr_in ? '0 : addr_q;
    wrap = h_out == H_LAST;
    last_out = wrap && v_out == V_LAST;
    h_d = !inc_in ? h_out : wrap ? '0 : h_out + 11'd1;
    v_d = !inc_in || !wrap ? v_out : last_out ? '0 : v_out + 10'd1;
    addr_d = !inc_in ? addr_out : last_out ? '0 : addr_out + 1'b1;
  end
  always_ff @(posedge clk_in) begin
    h_q <= !rst_n_in ? '0 : h_d;
    v_q <= !rst_n_in ? '0 : v_d;
    addr_q <= !rst_n_in ? '0 : addr_d;
  end
endmodule

// File: rtl/frame_writer.sv
// frame_writer: turns the camera raster stream into registered frame-buffer writes
// Ports: clk_in, rst_n_in (sync, active-low), bus (frame_writer_if.slave: pixel stream in,
// write strobe/address/data/coordinates and frame_done/short_frame/overflow status out).
// FRAME_WRITER_PINGPONG_EN: when defined the address MSB is a bank bit flipped after each
// completed frame; otherwise it stays 0.
module frame_writer
  import frame_pkg::*;
#(
  parameter int WIDTH = CAM_W,
  parameter int HEIGHT = CAM_H,
  parameter int PIX_W = DEF_PIX_W
) (
  input logic clk_in,
  input logic rst_n_in,
  frame_writer_if.slave bus
);
  localparam int ADDR_W = addr_w(WIDTH, HEIGHT);
  fw_state_t state_q, state_d;
  logic start, accept, last, toggle;
  logic [10:0] h;
  logic [9:0] v;
  logic [ADDR_W-1:0] addr;
  logic wr_en_q, wr_en_d, frame_done_q, frame_done_d;
  logic short_q, short_d, ovf_q, ovf_d, bank_q, bank_d;
  logic [ADDR_W:0] wr_addr_q, wr_addr_d;
  logic [PIX_W-1:0] wr_data_q, wr_data_d;
  logic [10:0] hcount_q, hcount_d;
  logic [9:0] vcount_q, vcount_d;
  assign start = bus.frame_start_in;
  // frame_start opens a frame in any state, so a coincident pixel is always accepted
  assign accept = bus.pixel_valid_in && (start || state_q == ACTIVE);
`ifdef FRAME_WRITER_PINGPONG_EN
  assign toggle = state_q == DONE;
`else
  assign toggle = 1'b0;
`endif
  raster_counter #(.WIDTH(WIDTH), .HEIGHT(HEIGHT)) u_raster (
    .clk_in(clk_in),
    .rst_n_in(rst_n_in),
    .clr_in(start),
    .inc_in(accept),
    .h_out(h),
    .v_out(v),
    .addr_out(addr),
    .last_out(last)
  );
  always_ff @(posedge clk_in) state_q <= !rst_n_in ? IDLE : state_d;
  always_comb begin
    state_d = accept && last ? DONE : start ? ACTIVE : state_q == DONE ? IDLE : state_q;
  end
  // bank_d is used for the address so a pixel arriving with frame_start in DONE lands in the new bank
  always_comb begin
    bank_d = bank_q ^ toggle;
    wr_en_d = accept;
    wr_addr_d = accept ? {bank_d, addr} : wr_addr_q;
    wr_data_d = accept ? bus.pixel_in : wr_data_q;
    hcount_d = accept ? h : hcount_q;
    vcount_d = accept ? v : vcount_q;
    frame_done_d = state_q == DONE;
    short_d = short_q || (start && state_q == ACTIVE);
    ovf_d = ovf_q || (bus.pixel_valid_in && !accept);
  end
  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      bank_q <= 1'b0;
      wr_en_q <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      hcount_q <= '0;
      vcount_q <= '0;
      frame_done_q <= 1'b0;
      short_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      bank_q <= bank_d;
      wr_en_q <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      hcount_q <= hcount_d;
      vcount_q <= vcount_d;
      frame_done_q <= frame_done_d;
      short_q <= short_d;
      ovf_q <= ovf_d;
    end
  end
  assign bus.wr_en_out = wr_en_q;
  assign bus.wr_addr_out = wr_addr_q;
  assign bus.wr_data_out = wr_data_q;
  assign bus.hcount_out = hcount_q;
  assign bus.vcount_out = vcount_q;
  assign bus.frame_done_out = frame_done_q;
  assign bus.short_frame_out = short_q;
  assign bus.overflow_out = ovf_q;
endmodule

// File: tb/tb_frame_writer.sv
// tb_frame_writer: directed stimulus on a reduced 8x6 raster against a frame-level write model
module tb_frame_writer;
  import frame_pkg::*;
  localparam int W = 8;
  localparam int H = 6;
  localparam int N = W * H;
  localparam int AW = addr_w(W, H);
`ifdef FRAME_WRITER_PINGPONG_EN
  localparam bit PP = 1'b1;
`else
  localparam bit PP = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  frame_writer_if #(.WIDTH(W), .HEIGHT(H), .PIX_W(16)) bus ();
  frame_writer #(.WIDTH(W), .HEIGHT(H), .PIX_W(16)) dut (
    .clk_in(clk),
    .rst_n_in(rst_n),
    .bus(bus)
  );
  always #5 clk = ~clk;
  int errors = 0;
  int checks = 0;
  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask
  // frame-level model: pixel k of an open frame goes to address k, column k%W, row k/W
  bit in_frame, done_pend, bank;
  int cnt;
  bit exp_wen, exp_done, exp_short, exp_ovf;
  logic [AW:0] exp_addr;
  logic [15:0] exp_data;
  logic [10:0] exp_h;
  logic [9:0] exp_v;
  always @(posedge clk) begin
    if (!rst_n) begin
      in_frame = 0; done_pend = 0; bank = 0; cnt = 0;
      exp_wen = 0; exp_done = 0; exp_short = 0; exp_ovf = 0;
      exp_addr = '0; exp_data = '0; exp_h = '0; exp_v = '0;
    end else begin
      exp_done = done_pend;
      done_pend = 0;
      if (exp_done && PP) bank = ~bank;
      if (bus.frame_start_in) begin
        if (in_frame) exp_short = 1;
        in_frame = 1;
        cnt = 0;
      end
      exp_wen = 0;
      if (bus.pixel_valid_in) begin
        if (in_frame) begin
          exp_wen = 1;
          exp_addr = {bank, AW'(cnt)};
          exp_h = 11'(cnt % W);
          exp_v = 10'(cnt / W);
          exp_data = bus.pixel_in;
          cnt++;
          if (cnt == N) begin
            in_frame = 0;
            done_pend = 1;
          end
        end else exp_ovf = 1;
      end
    end
  end
  int wr_cnt = 0;
  int done_cnt = 0;
  always @(negedge clk) begin
    chk("wr_en", bus.wr_en_out, exp_wen);
    chk("frame_done", bus.frame_done_out, exp_done);
    chk("short_frame", bus.short_frame_out, exp_short);
    chk("overflow", bus.overflow_out, exp_ovf);
    chk("wr_addr", bus.wr_addr_out, exp_addr);
    chk("wr_data", bus.wr_data_out, exp_data);
    chk("hcount", bus.hcount_out, exp_h);
    chk("vcount", bus.vcount_out, exp_v);
    if (bus.wr_en_out) wr_cnt++;
    if (bus.frame_done_out) done_cnt++;
  end
  task automatic drive(input bit fs, input bit pv, input logic [15:0] px);
    @(negedge clk);
    bus.frame_start_in = fs;
    bus.pixel_valid_in = pv;
    bus.pixel_in = px;
  endtask
  initial begin
    bus.frame_start_in = 0;
    bus.pixel_valid_in = 0;
    bus.pixel_in = '0;
    drive(0, 0, 0);
    drive(0, 0, 0);
    rst_n = 1'b1;
    chk("rst_wen", bus.wr_en_out, 0);
    chk("rst_addr", bus.wr_addr_out, 0);
    chk("rst_flags", {bus.frame_done_out, bus.short_frame_out, bus.overflow_out}, 0);
    drive(1, 0, 0);
    for (int i = 0; i < N; i++) drive(0, 1, 16'(i));
    drive(0, 0, 0);
    chk("f1_last_addr", bus.wr_addr_out, 47);
    chk("f1_last_h", bus.hcount_out, 7);
    chk("f1_last_v", bus.vcount_out, 5);
    chk("f1_last_data", bus.wr_data_out, 47);
    chk("f1_done_not_yet", bus.frame_done_out, 0);
    drive(0, 0, 0);
    chk("f1_done_pulse", bus.frame_done_out, 1);
    drive(0, 0, 0);
    chk("f1_done_cnt", done_cnt, 1);
    chk("f1_wr_cnt", wr_cnt, 48);
    chk("f1_no_ovf", bus.overflow_out, 0);
    drive(0, 1, 16'hDEAD);
    drive(0, 1, 16'hBEEF);
    drive(0, 0, 0);
    chk("post_ovf", bus.overflow_out, 1);
    chk("post_wr_cnt", wr_cnt, 48);
    drive(1, 0, 0);
    begin
      int sent;
      int k;
      bit v;
      sent = 0;
      k = 0;
      while (sent < N) begin
        v = (k % 4 == 0) || (k % 4 == 3);
        drive(0, v, 16'(sent + 256));
        if (v) sent++;
        k++;
      end
    end
    drive(0, 0, 0);
    chk("f2_last_addr", bus.wr_addr_out, PP ? 64 + 47 : 47);
    drive(0, 0, 0);
    drive(0, 0, 0);
    chk("f2_done_cnt", done_cnt, 2);
    chk("f2_wr_cnt", wr_cnt, 96);
    drive(1, 0, 0);
    for (int i = 0; i < 20; i++) drive(0, 1, 16'(i + 512));
    drive(1, 1, 16'h5555);
    drive(0, 0, 0);
    chk("short_flag", bus.short_frame_out, 1);
    chk("short_addr", bus.wr_addr_out, 0);
    chk("short_hv", {bus.hcount_out, bus.vcount_out}, 0);
    chk("short_data", bus.wr_data_out, 16'h5555);
    chk("short_no_done", done_cnt, 2);
    for (int i = 1; i < N; i++) drive(0, 1, 16'(i + 1024));
    drive(0, 0, 0);
    drive(0, 0, 0);
    drive(0, 0, 0);
    chk("f3_done_cnt", done_cnt, 3);
    drive(1, 0, 0);
    for (int i = 0; i < 10; i++) drive(0, 1, 16'(i + 2048));
    drive(0, 1, 16'h7777);
    rst_n = 1'b0;
    drive(0, 0, 0);
    rst_n = 1'b1;
    chk("mid_rst_wen", bus.wr_en_out, 0);
    chk("mid_rst_addr", bus.wr_addr_out, 0);
    chk("mid_rst_flags", {bus.frame_done_out, bus.short_frame_out, bus.overflow_out}, 0);
    drive(0, 1, 16'h1111);
    drive(0, 0, 0);
    chk("pre_start_ovf", bus.overflow_out, 1);
    chk("pre_start_wen", bus.wr_en_out, 0);
    drive(1, 1, 16'h0F0F);
    drive(0, 0, 0);
    chk("f5_first_addr", bus.wr_addr_out, 0);
    chk("f5_first_data", bus.wr_data_out, 16'h0F0F);
    chk("aborted_no_done", done_cnt, 3);
    for (int i = 1; i < N; i++) drive(0, 1, 16'(i + 4096));
    drive(0, 0, 0);
    drive(0, 0, 0);
    drive(0, 0, 0);
    chk("f5_done_cnt", done_cnt, 4);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
